// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle of the mul/div controller, including the operand and
// product lines of the external multiplier.
interface muldiv_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] mul_p;
    logic        done;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, cancel, mul_p,
        output req_ready, mul_a, mul_b, done, res_hi, res_lo, busy
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, cancel, mul_p,
        input  req_ready, mul_a, mul_b, done, res_hi, res_lo, busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/multu/div/divu controller: feeds an external multiplier and
// runs a 32-step restoring divider. Define MULDIV_DIV0_FAST_EN to finish divide-by-zero in one cycle.
module muldiv_ctrl #(
    parameter int unsigned MULT_LAT = 1
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MULT_LAT - 1);

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        op_signed;
    logic        src2_zero;
    logic [31:0] src1_mag;
    logic [31:0] src2_mag;
    logic [32:0] trial;
    logic        mul_last;
    logic        div_last;

    logic [3:0]  mul_cnt;
    logic [4:0]  div_cnt;
    logic [32:0] mul_a_q;
    logic [32:0] mul_b_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dsr_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic        div0_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic        mul_p_unused;

    assign accept    = bus.req_valid & (state == S_IDLE) & ~bus.cancel;
    assign op_signed = ~bus.req_op[0];
    assign src2_zero = (bus.req_src2 == 32'd0);
    assign src1_mag  = (op_signed && bus.req_src1[31]) ? (~bus.req_src1 + 32'd1) : bus.req_src1;
    assign src2_mag  = (op_signed && bus.req_src2[31]) ? (~bus.req_src2 + 32'd1) : bus.req_src2;

    // quo_q starts as the dividend magnitude; each step shifts its MSB into the
    // partial remainder and the new quotient bit into its LSB.
    assign trial    = {rem_q, quo_q[31]} - {1'b0, dsr_q};
    assign mul_last = (mul_cnt == MUL_LAST);
    assign div_last = (div_cnt == 5'd31);

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.res_lo    = res_lo_q;

    // The 33x33 product only ever yields 64 meaningful bits.
    assign mul_p_unused = ^bus.mul_p[65:64];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!bus.req_op[1]) begin
                        state_nxt = S_MUL;
`ifdef MULDIV_DIV0_FAST_EN
                    end else if (src2_zero) begin
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (bus.cancel)    state_nxt = S_IDLE;
                else if (mul_last) state_nxt = S_DONE;
            end
            S_DIV: begin
                if (bus.cancel)    state_nxt = S_IDLE;
                else if (div_last) state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = bus.cancel ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_cnt   <= '0;
            div_cnt   <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_cnt <= '0;
                        div_cnt <= '0;
                        if (!bus.req_op[1]) begin
                            mul_a_q <= {op_signed & bus.req_src1[31], bus.req_src1};
                            mul_b_q <= {op_signed & bus.req_src2[31], bus.req_src2};
                        end else begin
                            quo_q     <= src1_mag;
                            rem_q     <= '0;
                            dsr_q     <= src2_mag;
                            quo_neg_q <= op_signed & (bus.req_src1[31] ^ bus.req_src2[31]);
                            rem_neg_q <= op_signed & bus.req_src1[31];
                            div0_q    <= src2_zero;
`ifdef MULDIV_DIV0_FAST_EN
                            if (src2_zero) begin
                                res_hi_q <= bus.req_src1;
                                res_lo_q <= 32'hFFFF_FFFF;
                            end
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.cancel) begin
                        mul_cnt <= mul_cnt + 4'd1;
                        if (mul_last) begin
                            res_hi_q <= bus.mul_p[63:32];
                            res_lo_q <= bus.mul_p[31:0];
                        end
                    end
                end
                S_DIV: begin
                    if (!bus.cancel) begin
                        div_cnt <= div_cnt + 5'd1;
                        if (!trial[32]) begin
                            rem_q <= trial[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= {rem_q[30:0], quo_q[31]};
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                    end
                end
                S_FIX: begin
                    // A zero divisor leaves |dividend| in rem_q, so the sign fix restores src1 there.
                    if (!bus.cancel) begin
                        res_hi_q <= rem_neg_q ? (~rem_q + 32'd1) : rem_q;
                        if (div0_q)         res_lo_q <= 32'hFFFF_FFFF;
                        else if (quo_neg_q) res_lo_q <= ~quo_q + 32'd1;
                        else                res_lo_q <= quo_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 1, SHALL set the cycles the external multiplier needs from stable operands to valid mul_p (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous active-low reset.
REQ-004 req_valid  input  1  SHALL flag a mul/div request from EXE.
REQ-005 req_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-006 req_op  input  2  SHALL select the operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 req_src1 / req_src2  input  32 each  SHALL carry the multiplicand/dividend and the multiplier/divisor.
REQ-008 cancel  input  1  SHALL carry the exception/flush kill of the in-flight operation.
REQ-009 mul_a / mul_b  output  33 each  SHALL carry the sign- or zero-extended operands to the external multiplier.
REQ-010 mul_p  input  66  SHALL carry the external multiplier product.
REQ-011 done  output  1  SHALL pulse for one cycle when res_hi/res_lo are valid.
REQ-012 res_hi / res_lo  output  32 each  SHALL carry the HI and LO results.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, FIX and DONE; req_ready SHALL equal (state==IDLE).
REQ-015 Accept SHALL occur at an edge where req_valid & req_ready & ~cancel; operands and op SHALL be latched at that edge.
REQ-016 On an op[1]=0 accept, the FSM SHALL enter MUL; mul_a/mul_b SHALL be registered {signext?src[31]:0, src} and held constant until the next accept.
REQ-017 MUL SHALL last exactly MULT_LAT cycles (4-bit counter), then go to DONE, capturing mul_p[63:32] into res_hi and mul_p[31:0] into res_lo.
REQ-018 On an op[1]=1 accept, the FSM SHALL enter DIV and run 32 restoring shift-subtract iterations on operand magnitudes, one quotient bit per cycle, MSB first, using a 5-bit counter.
REQ-019 After iteration 31, DIV SHALL go to FIX, which negates the quotient when signed and the operand signs differ, and negates the remainder when signed and the dividend is negative.
REQ-020 FIX SHALL go to DONE with res_lo=quotient and res_hi=remainder.
REQ-021 Division by zero SHALL yield res_hi=req_src1 and res_lo=0xFFFFFFFF for both div and divu.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; res_hi/res_lo SHALL hold until the next capture.
REQ-023 Latency SHALL be measured from the accept edge E: a mul asserts done in cycle E+MULT_LAT+1 and a non-zero-divisor div in cycle E+34.
REQ-024 cancel in MUL, DIV or FIX SHALL force IDLE at the next edge, with no done and res_hi/res_lo unchanged.
REQ-025 cancel in DONE SHALL not suppress that cycle's done pulse.
REQ-026 cancel together with req_valid in IDLE SHALL win, and the request SHALL not be accepted.
REQ-027 A new request SHALL not be accepted in the DONE cycle; the earliest back-to-back accept SHALL be the cycle after done.
REQ-028 The signed division 0x80000000 / 0xFFFFFFFF SHALL give res_lo=0x80000000 and res_hi=0.

Reset
REQ-029 While resetn=0: state=IDLE, req_ready=1, busy=0, done=0, res_hi=res_lo=0, mul_a=mul_b=0, counters=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no done; the first accept is legal at the first edge after resetn rises.

Configuration
REQ-031 Macro MULDIV_DIV0_FAST_EN defined: a divisor of zero at accept SHALL go straight to DONE, with done in cycle E+1.
REQ-032 Macro MULDIV_DIV0_FAST_EN undefined: a divisor of zero SHALL take the full DIV/FIX path (done in cycle E+34); results per REQ-021 in both builds.

Verification
REQ-033 multu 0xFFFFFFFF*0xFFFFFFFF, MULT_LAT=1 -> done in cycle E+2, res_hi=0xFFFFFFFE, res_lo=0x00000001.
REQ-034 mult 0xFFFFFFFE*0x00000003 -> mul_a=0x1FFFFFFFE, res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA.
REQ-035 div 0xFFFFFFF9/0x00000002 (-7/2) -> done in cycle E+34, res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF; divu 100/7 -> res_lo=14, res_hi=2.
REQ-036 divu 0x00000007/0 -> res_hi=7, res_lo=0xFFFFFFFF; done in cycle E+1 with the macro, E+34 without.
REQ-037 cancel at DIV iteration 10 -> no done, req_ready=1 next cycle, following multu 3*5 -> res_lo=15, res_hi=0.
REQ-038 resetn pulsed low during MUL -> all outputs at reset values within the same cycle, no done; div 0x80000000/0xFFFFFFFF afterward -> res_lo=0x80000000, res_hi=0.
